// File: rtl/gba_mem_pkg.sv
// gba_mem_pkg
//   Shared types and constants for the GBA memory bus controller:
//   region enum, FSM state encoding, region base nibbles, mirror masks,
//   default wait-state counts and the address-map decode helpers.
package gba_mem_pkg;

    // Backend region select; the numeric value is driven on ram_sel.
    typedef enum logic [2:0] {
        REG_BIOS  = 3'd0,
        REG_EWRAM = 3'd1,
        REG_IWRAM = 3'd2,
        REG_ROM   = 3'd3,
        REG_NONE  = 3'd4
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Transfer sizes; any other code behaves as a word.
    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;

    // Region base nibbles, compared against addr[27:24] with addr[31:28]==0.
    localparam logic [3:0] BASE_BIOS   = 4'h0;
    localparam logic [3:0] BASE_EWRAM  = 4'h2;
    localparam logic [3:0] BASE_IWRAM  = 4'h3;
    localparam logic [3:0] BASE_ROM_LO = 4'h8;
    localparam logic [3:0] BASE_ROM_HI = 4'hD;

    // Word-index mirror masks applied to addr[24:2].
    localparam logic [22:0] MASK_BIOS  = 23'h000FFF;  // addr[13:2]
    localparam logic [22:0] MASK_EWRAM = 23'h00FFFF;  // addr[17:2]
    localparam logic [22:0] MASK_IWRAM = 23'h001FFF;  // addr[14:2]
    localparam logic [22:0] MASK_ROM   = 23'h7FFFFF;  // addr[24:2]

    // Default wait-state counts.
    localparam int WS_BIOS_DEF  = 0;
    localparam int WS_EWRAM_DEF = 2;
    localparam int WS_IWRAM_DEF = 0;
    localparam int WS_ROM_DEF   = 4;

    localparam int WS_CNT_W = 8;

    function automatic region_e decode_region(input logic [31:0] addr);
        region_e r;
        r = REG_NONE;
        if (addr[31:28] == 4'h0) begin
            if (addr[27:24] == BASE_BIOS) begin
                r = REG_BIOS;
            end else if (addr[27:24] == BASE_EWRAM) begin
                r = REG_EWRAM;
            end else if (addr[27:24] == BASE_IWRAM) begin
                r = REG_IWRAM;
            end else if ((addr[27:24] >= BASE_ROM_LO) && (addr[27:24] <= BASE_ROM_HI)) begin
                r = REG_ROM;
            end
        end
        return r;
    endfunction

    function automatic logic [22:0] mirror_mask(input region_e r);
        logic [22:0] m;
        case (r)
            REG_BIOS:  m = MASK_BIOS;
            REG_EWRAM: m = MASK_EWRAM;
            REG_IWRAM: m = MASK_IWRAM;
            REG_ROM:   m = MASK_ROM;
            default:   m = 23'h0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/gba_mem_lane.sv
// gba_mem_lane
//   Combinational byte-lane logic for the memory controller.
//   Store side: byte enables and lane-replicated write data.
//   Load side: byte/half zero-extended extraction and word rotate.
// Ports:
//   addr_lo       in  2  : request address bits [1:0]
//   width         in  2  : 0=byte, 1=half, 2/3=word
//   wdata         in  32 : right-aligned store data
//   rdata         in  32 : raw backend read word
//   be            out 4  : byte enables
//   wdata_lanes   out 32 : store data replicated across lanes
//   rdata_aligned out 32 : formatted load data
module gba_mem_lane
    import gba_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  width,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_aligned
);

    logic is_byte;
    logic is_half;
    logic [31:0] rdata_rot;

    assign is_byte = (width == WIDTH_BYTE);
    assign is_half = (width == WIDTH_HALF);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            localparam int HALF_SRC = 8 * (gi % 2);
            localparam int WORD_SRC = 8 * gi;

            // Half stores ignore addr[0]; word stores ignore addr[1:0].
            assign be[gi] = is_byte ? (addr_lo == LANE)
                          : is_half ? (addr_lo[1] == LANE[1])
                          : 1'b1;

            assign wdata_lanes[8*gi +: 8] = is_byte ? wdata[7:0]
                                          : is_half ? wdata[HALF_SRC +: 8]
                                          : wdata[WORD_SRC +: 8];
        end
    endgenerate

    // Rotate right by 8*addr[1:0]; the addressed byte lands in [7:0],
    // which also serves the byte-load path.
    always_comb begin
        case (addr_lo)
            2'd1:    rdata_rot = {rdata[7:0],  rdata[31:8]};
            2'd2:    rdata_rot = {rdata[15:0], rdata[31:16]};
            2'd3:    rdata_rot = {rdata[23:0], rdata[31:24]};
            default: rdata_rot = rdata;
        endcase
    end

    always_comb begin
        rdata_aligned = rdata_rot;
        if (is_byte) begin
            rdata_aligned = {24'h0, rdata_rot[7:0]};
        end else if (is_half) begin
            rdata_aligned = {16'h0, (addr_lo[1] ? rdata[31:16] : rdata[15:0])};
        end
    end

endmodule

// File: rtl/gba_mem_ctrl.sv
// gba_mem_ctrl
//   Memory bus controller between the CPU core and a synchronous backing
//   memory. Accepts one request at a time, decodes the GBA map, inserts
//   per-region wait states, performs one backend access and returns the
//   formatted result with a one-cycle mem_ok pulse.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   mem_addr/wdata/width/read/write in : CPU request (held until mem_ok)
//   mem_rdata, mem_ok out              : response
//   ram_sel/addr/en/we/be/wdata out    : backend access port
//   ram_rdata in                       : backend data, valid cycle after ram_en
module gba_mem_ctrl
    import gba_mem_pkg::*;
#(
    parameter int WS_BIOS  = WS_BIOS_DEF,
    parameter int WS_EWRAM = WS_EWRAM_DEF,
    parameter int WS_IWRAM = WS_IWRAM_DEF,
    parameter int WS_ROM   = WS_ROM_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic [1:0]  mem_width,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_ok,
    output logic [2:0]  ram_sel,
    output logic [22:0] ram_addr,
    output logic        ram_en,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_e                state_reg, state_next;
    logic [WS_CNT_W-1:0]   cnt_reg, cnt_next;
    logic [24:0]           addr_reg;
    logic [1:0]            width_reg;
    logic [31:0]           wdata_reg;
    logic                  dir_reg;     // 1 = write
    region_e               region_reg;

    region_e               req_region;
    logic [WS_CNT_W-1:0]   req_ws;
    logic                  req_valid;
    logic                  accept;
    logic                  access_ok;

    logic [3:0]            lane_be;
    logic [31:0]           lane_wdata;
    logic [31:0]           lane_rdata;

    assign req_region = decode_region(mem_addr);
    assign req_valid  = mem_read | mem_write;
    assign accept     = (state_reg == ST_IDLE) && req_valid;

    always_comb begin
        case (req_region)
            REG_BIOS:  req_ws = WS_CNT_W'(WS_BIOS);
            REG_EWRAM: req_ws = WS_CNT_W'(WS_EWRAM);
            REG_IWRAM: req_ws = WS_CNT_W'(WS_IWRAM);
            REG_ROM:   req_ws = WS_CNT_W'(WS_ROM);
            default:   req_ws = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_next = req_ws;
                    if (req_region == REG_NONE) begin
                        state_next = ST_RESP;
                    end else if (req_ws == '0) begin
                        state_next = ST_ACCESS;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg <= WS_CNT_W'(1)) begin
                    state_next = ST_ACCESS;
                end else begin
                    cnt_next = cnt_reg - WS_CNT_W'(1);
                end
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            width_reg  <= '0;
            wdata_reg  <= '0;
            dir_reg    <= 1'b0;
            region_reg <= REG_BIOS;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg   <= mem_addr[24:0];
                width_reg  <= mem_width;
                wdata_reg  <= mem_wdata;
                dir_reg    <= mem_write;   // write wins over read
                region_reg <= req_region;
            end
        end
    end

    gba_mem_lane u_lane (
        .addr_lo       (addr_reg[1:0]),
        .width         (width_reg),
        .wdata         (wdata_reg),
        .rdata         (ram_rdata),
        .be            (lane_be),
        .wdata_lanes   (lane_wdata),
        .rdata_aligned (lane_rdata)
    );

    // BIOS and ROM are read-only: writes there complete without touching
    // the backend. Unmapped requests never reach ACCESS.
    assign access_ok = (region_reg != REG_NONE)
                    && !(dir_reg && ((region_reg == REG_BIOS) || (region_reg == REG_ROM)));

    // Strobes decode from registered state and are masked by rst so that
    // a reset sampled during ACCESS cannot commit a write on that edge.
    assign ram_en    = (state_reg == ST_ACCESS) && access_ok && !rst;
    assign ram_we    = ram_en && dir_reg;
    assign ram_be    = ram_en ? lane_be : 4'b0000;
    assign ram_wdata = lane_wdata;
    assign ram_sel   = region_reg;
    assign ram_addr  = addr_reg[24:2] & mirror_mask(region_reg);

    assign mem_ok    = (state_reg == ST_RESP) && !rst;
    assign mem_rdata = (mem_ok && (region_reg != REG_NONE) && !dir_reg) ? lane_rdata : 32'h0;

endmodule

// File: tb/tb_gba_mem_ctrl.sv
module tb_gba_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_width;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ok;
    logic [2:0]  ram_sel;
    logic [22:0] ram_addr;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] backend_word;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rdata;
        int          ok_lat;
        bit          chk_rdata;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    gba_mem_ctrl #(
        .WS_BIOS  (0),
        .WS_EWRAM (2),
        .WS_IWRAM (0),
        .WS_ROM   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_width (mem_width),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_ok    (mem_ok),
        .ram_sel   (ram_sel),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_be    (ram_be),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous backend model: data appears the cycle after a read strobe,
    // otherwise a poison pattern.
    always @(posedge clk) begin
        if (ram_en && !ram_we) ram_rdata <= backend_word;
        else                   ram_rdata <= 32'hBAD0_BAD0;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE. Latencies are counted in
    // cycles after T (the cycle whose closing edge samples the request).
    task automatic run_req(
        input string       name,
        input logic [31:0] addr,
        input logic [1:0]  width,
        input logic        rd,
        input logic        wr,
        input logic [31:0] wdata,
        input logic [31:0] backend,
        input int          en_lat,
        input logic [2:0]  sel,
        input logic [22:0] raddr,
        input logic [3:0]  be,
        input logic [31:0] rwdata,
        input logic        we,
        input int          ok_lat,
        input bit          chk_rdata,
        input logic [31:0] rdata
    );
        exp_t e;
        exp_t g;
        int   en_seen;
        int   ok_seen;
        bit   done;
        en_seen = -1;
        ok_seen = -1;
        done    = 1'b0;
        mem_addr     = addr;
        mem_width    = width;
        mem_wdata    = wdata;
        mem_read     = rd;
        mem_write    = wr;
        backend_word = backend;
        e.rdata     = rdata;
        e.ok_lat    = ok_lat;
        e.chk_rdata = chk_rdata;
        exp_q.push_back(e);
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (ram_en && en_seen < 0) begin
                en_seen = k;
                check_val({name, "/ram_sel"},  32'(ram_sel),  32'(sel));
                check_val({name, "/ram_addr"}, 32'(ram_addr), 32'(raddr));
                check_val({name, "/ram_we"},   32'(ram_we),   32'(we));
                if (we) begin
                    check_val({name, "/ram_be"},    32'(ram_be), 32'(be));
                    check_val({name, "/ram_wdata"}, ram_wdata,   rwdata);
                end
            end
            if (mem_ok) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
                ok_seen   = k;
                done      = 1'b1;
                check_val({name, "/en_cycle"}, 32'(en_seen), 32'(en_lat));
                if (exp_q.size() == 0) begin
                    check_val({name, "/sb_empty"}, 32'd0, 32'd1);
                end else begin
                    g = exp_q.pop_front();
                    check_val({name, "/ok_cycle"}, 32'(k), 32'(g.ok_lat));
                    if (g.chk_rdata) check_val({name, "/mem_rdata"}, mem_rdata, g.rdata);
                end
            end
        end
        if (!done) begin
            check_val({name, "/timeout"}, 32'd0, 32'd1);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            exp_q.delete();
        end
        @(negedge clk);
        check_val({name, "/ok_gap"}, 32'(mem_ok), 32'd0);
        $display("txn %-16s addr=0x%08h en@T+%0d ok@T+%0d rdata=0x%08h",
                 name, addr, en_seen, ok_seen, mem_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_width    = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        backend_word = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst/mem_ok",    32'(mem_ok),   32'd0);
        check_val("rst/ram_en",    32'(ram_en),   32'd0);
        check_val("rst/ram_we",    32'(ram_we),   32'd0);
        check_val("rst/ram_be",    32'(ram_be),   32'd0);
        check_val("rst/mem_rdata", mem_rdata,     32'd0);
        check_val("rst/ram_sel",   32'(ram_sel),  32'd0);
        check_val("rst/ram_addr",  32'(ram_addr), 32'd0);
        check_val("rst/ram_wdata", ram_wdata,     32'd0);

        //       name               addr          w    rd    wr    wdata         backend       en  sel   raddr        be       rwdata        we    ok  chk  rdata
        run_req("iwram_word_rd",   32'h03000004, 2'd2, 1'b1, 1'b0, 32'h0,        32'hDEADBEEF, 1,  3'd2, 23'h000001, 4'b1111, 32'h0,        1'b0, 2,  1, 32'hDEADBEEF);
        run_req("ewram_byte_wr",   32'h02000003, 2'd0, 1'b0, 1'b1, 32'h000000A5, 32'h0,        3,  3'd1, 23'h000000, 4'b1000, 32'hA5A5A5A5, 1'b1, 4,  0, 32'h0);
        run_req("rom_word_rd",     32'h08000002, 2'd2, 1'b1, 1'b0, 32'h0,        32'h11223344, 5,  3'd3, 23'h000000, 4'b1111, 32'h0,        1'b0, 6,  1, 32'h33441122);
        run_req("unmapped_rd",     32'h05000000, 2'd2, 1'b1, 1'b0, 32'h0,        32'h77777777, -1, 3'd0, 23'h000000, 4'b0000, 32'h0,        1'b0, 1,  1, 32'h00000000);
        run_req("bios_wr_drop",    32'h00000010, 2'd2, 1'b0, 1'b1, 32'h12345678, 32'h0,        -1, 3'd0, 23'h000000, 4'b0000, 32'h0,        1'b1, 2,  0, 32'h0);
        run_req("ewram_half_wr",   32'h02000007, 2'd1, 1'b0, 1'b1, 32'hFFFF1234, 32'h0,        3,  3'd1, 23'h000001, 4'b1100, 32'h12341234, 1'b1, 4,  0, 32'h0);
        run_req("ewram_half_wr_lo",32'h02000009, 2'd1, 1'b0, 1'b1, 32'h0000BEEF, 32'h0,        3,  3'd1, 23'h000002, 4'b0011, 32'hBEEFBEEF, 1'b1, 4,  0, 32'h0);
        run_req("iwram_half_rd",   32'h0300000F, 2'd1, 1'b1, 1'b0, 32'h0,        32'hAABBCCDD, 1,  3'd2, 23'h000003, 4'b0000, 32'h0,        1'b0, 2,  1, 32'h0000AABB);
        run_req("iwram_byte_rd",   32'h03000001, 2'd0, 1'b1, 1'b0, 32'h0,        32'h11223344, 1,  3'd2, 23'h000000, 4'b0000, 32'h0,        1'b0, 2,  1, 32'h00000033);
        run_req("ewram_mirror_rd", 32'h02040008, 2'd3, 1'b1, 1'b0, 32'h0,        32'h01020304, 3,  3'd1, 23'h000002, 4'b0000, 32'h0,        1'b0, 4,  1, 32'h01020304);
        run_req("iwram_mirror_rd", 32'h03008013, 2'd2, 1'b1, 1'b0, 32'h0,        32'h0A0B0C0D, 1,  3'd2, 23'h000004, 4'b0000, 32'h0,        1'b0, 2,  1, 32'h0B0C0D0A);
        run_req("rom_hi_half_rd",  32'h0D000100, 2'd1, 1'b1, 1'b0, 32'h0,        32'h55667788, 5,  3'd3, 23'h400040, 4'b0000, 32'h0,        1'b0, 6,  1, 32'h00007788);
        run_req("rd_wr_both",      32'h03000020, 2'd2, 1'b1, 1'b1, 32'h12345678, 32'h0,        1,  3'd2, 23'h000008, 4'b1111, 32'h12345678, 1'b1, 2,  0, 32'h0);
        run_req("rom_wr_drop",     32'h08000000, 2'd2, 1'b0, 1'b1, 32'hCAFEBABE, 32'h0,        -1, 3'd3, 23'h000000, 4'b0000, 32'h0,        1'b1, 6,  0, 32'h0);
        run_req("bios_rd_mirror",  32'h00004004, 2'd2, 1'b1, 1'b0, 32'h0,        32'h99887766, 1,  3'd0, 23'h000001, 4'b0000, 32'h0,        1'b0, 2,  1, 32'h99887766);

        // EWRAM word write with rst held across the ACCESS cycle (T+3).
        mem_addr  = 32'h02000010;
        mem_width = 2'd2;
        mem_wdata = 32'hCAFEF00D;
        mem_write = 1'b1;
        @(negedge clk);              // T+1
        @(negedge clk);              // T+2
        @(posedge clk);
        #1 rst = 1'b1;               // whole of T+3 under reset
        @(negedge clk);              // T+3, ACCESS
        check_val("rst_access/ram_en", 32'(ram_en), 32'd0);
        check_val("rst_access/ram_we", 32'(ram_we), 32'd0);
        check_val("rst_access/mem_ok", 32'(mem_ok), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);              // T+4, back in IDLE
        check_val("rst_after/mem_ok", 32'(mem_ok), 32'd0);
        check_val("rst_after/ram_en", 32'(ram_en), 32'd0);
        $display("txn %-16s addr=0x%08h aborted by reset in ACCESS", "ewram_wr_rst", 32'h02000010);

        run_req("post_rst_rd",     32'h03000008, 2'd2, 1'b1, 1'b0, 32'h0,        32'h0F1E2D3C, 1,  3'd2, 23'h000002, 4'b0000, 32'h0,        1'b0, 2,  1, 32'h0F1E2D3C);

        check_val("sb/drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
